dac_tx_sequencer: RTL

DAC_TX_SEQUENCER -- requirements
Module: dac_tx_sequencer

---
 rtl/dac_tx_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/dac_tx_sequencer.sv
// -----------------------------------------------------------------------------
// dac_tx_sequencer
//
// Sequences the DAC transmit stream onto a JESD link: waits for link ready,
// sends a programmable number of zero "prefill" words, then streams DMA
// samples with one cycle of latency. It counts DMA underflow words and
// link-loss events (STREAM -> WAIT_READY exits) in saturating counters.
//
// Parameters
//   DATA_WIDTH      width of tx_data / dac_ddata (4 lanes x 32 bit)
//   CNT_WIDTH       width of the underflow and link-loss counters
//
// Ports
//   dac_clk          single clock, all logic in this domain
//   dac_rst          asynchronous active-high reset
//   cfg_enable       level: 1 requests streaming, 0 forces IDLE
//   cfg_prefill      number of zero words sent before DMA data
//   cfg_cnt_clr      single-cycle pulse clearing both counters
//   tx_ready         JESD link ready (word consumed when tx_valid & tx_ready)
//   tx_valid         registered data valid to the link
//   tx_data          registered data to the link
//   dac_valid        combinational sample request to the DMA source
//   dac_ddata        DMA data, valid in the dac_valid cycle
//   dac_dunf         DMA underflow, qualified by dac_valid
//   seq_state        state: 0 IDLE, 1 WAIT_READY, 2 PREFILL, 3 STREAM
//   dunf_count       saturating count of underflow words
//   link_loss_count  saturating count of STREAM -> WAIT_READY exits
//
// Build option
//   DAC_TX_SEQ_DUNF_HOLD_EN  when defined, an underflow word repeats the last
//                            good word sent since entering STREAM (zero if
//                            none); when undefined, underflow words are zero.
// -----------------------------------------------------------------------------
module dac_tx_sequencer #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  dac_clk,
    input  logic                  dac_rst,
    input  logic                  cfg_enable,
    input  logic [7:0]            cfg_prefill,
    input  logic                  cfg_cnt_clr,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  dac_valid,
    input  logic [DATA_WIDTH-1:0] dac_ddata,
    input  logic                  dac_dunf,
    output logic [1:0]            seq_state,
    output logic [CNT_WIDTH-1:0]  dunf_count,
    output logic [CNT_WIDTH-1:0]  link_loss_count
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_READY = 2'd1,
        ST_PREFILL    = 2'd2,
        ST_STREAM     = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_reg, state_next;
    logic [7:0]             prefill_cnt_reg, prefill_cnt_next;
    logic                   tx_valid_reg, tx_valid_next;
    logic [DATA_WIDTH-1:0]  tx_data_reg, tx_data_next;
    logic [DATA_WIDTH-1:0]  uf_word;
    logic                   link_loss_inc;
    logic [1:0]             cnt_inc;
    logic [CNT_WIDTH-1:0]   cnt_reg [2];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            state_reg       <= ST_IDLE;
            prefill_cnt_reg <= 8'd0;
            tx_valid_reg    <= 1'b0;
            tx_data_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            prefill_cnt_reg <= prefill_cnt_next;
            tx_valid_reg    <= tx_valid_next;
            tx_data_reg     <= tx_data_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Dropping cfg_enable overrides every other transition.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        prefill_cnt_next = prefill_cnt_reg;
        link_loss_inc    = 1'b0;

        if (!cfg_enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_WAIT_READY;
                end
                ST_WAIT_READY: begin
                    if (tx_ready) begin
                        // cfg_prefill is only sampled here; later changes
                        // cannot disturb a prefill already in progress.
                        if (cfg_prefill == 8'd0) begin
                            state_next = ST_STREAM;
                        end else begin
                            state_next       = ST_PREFILL;
                            prefill_cnt_next = cfg_prefill;
                        end
                    end
                end
                ST_PREFILL: begin
                    if (!tx_ready) begin
                        state_next = ST_WAIT_READY;
                    end else begin
                        prefill_cnt_next = prefill_cnt_reg - 8'd1;
                        if (prefill_cnt_reg <= 8'd1) begin
                            state_next = ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (!tx_ready) begin
                        state_next    = ST_WAIT_READY;
                        link_loss_inc = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath. tx_valid is computed from the next state so that it is already
    // high during every PREFILL cycle; STREAM words lag dac_valid by one clock.
    // dac_valid implies the next state is STREAM, so IDLE/WAIT_READY always
    // register valid=0 / data=0.
    // -------------------------------------------------------------------------
    assign dac_valid = (state_reg == ST_STREAM) && tx_ready && cfg_enable;

    always_comb begin
        tx_valid_next = dac_valid || (state_next == ST_PREFILL);
        tx_data_next  = '0;
        if (dac_valid) begin
            tx_data_next = dac_dunf ? uf_word : dac_ddata;
        end
    end

`ifdef DAC_TX_SEQ_DUNF_HOLD_EN
    // Last good word since entering STREAM; cleared whenever outside STREAM.
    logic [DATA_WIDTH-1:0] hold_reg;

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            hold_reg <= '0;
        end else if (state_reg != ST_STREAM) begin
            hold_reg <= '0;
        end else if (dac_valid && !dac_dunf) begin
            hold_reg <= dac_ddata;
        end
    end

    assign uf_word = hold_reg;
`else
    assign uf_word = '0;
`endif

    // -------------------------------------------------------------------------
    // Saturating event counters: [0] underflow words, [1] link-loss exits.
    // A clear pulse beats a coincident increment.
    // -------------------------------------------------------------------------
    assign cnt_inc[0] = dac_valid && dac_dunf;
    assign cnt_inc[1] = link_loss_inc;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge dac_clk or posedge dac_rst) begin
                if (dac_rst) begin
                    cnt_reg[gi] <= '0;
                end else if (cfg_cnt_clr) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_WIDTH{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
                end
            end
        end
    endgenerate

    assign tx_valid        = tx_valid_reg;
    assign tx_data         = tx_data_reg;
    assign seq_state       = state_reg;
    assign dunf_count      = cnt_reg[0];
    assign link_loss_count = cnt_reg[1];

endmodule
